// File: rtl/tinker_exec_unit_if.sv
// tinker_exec_unit_if
//   Bundles the execute-stage signals between the CPU control/datapath and
//   tinker_exec_unit.
//   master : CPU side. Drives exec_en, instr, pc, the operands and in_data.
//            Receives the decoded fields, the controls, the result and status.
//   slave  : execute unit side (the reverse directions).
//   Port summary (width):
//     exec_en(1) instr(32) pc(64) rd_data/rs_data/rt_data(64) in_data(64)
//     rd/rs/rt(5) L(12) reg_write(1) pc_src(1) alu_result(64)
//     halt(1) error(1) in_signal(1) out_signal(1) out_data(64)
interface tinker_exec_unit_if;
  logic        exec_en;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] rd_data;
  logic [63:0] rs_data;
  logic [63:0] rt_data;
  logic [63:0] in_data;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [11:0] L;
  logic        reg_write;
  logic        pc_src;
  logic [63:0] alu_result;
  logic        halt;
  logic        error;
  logic        in_signal;
  logic        out_signal;
  logic [63:0] out_data;

  modport master (
    output exec_en, instr, pc, rd_data, rs_data, rt_data, in_data,
    input  rd, rs, rt, L, reg_write, pc_src, alu_result,
           halt, error, in_signal, out_signal, out_data
  );

  modport slave (
    input  exec_en, instr, pc, rd_data, rs_data, rt_data, in_data,
    output rd, rs, rt, L, reg_write, pc_src, alu_result,
           halt, error, in_signal, out_signal, out_data
  );
endinterface

// File: rtl/tinker_exec_unit.sv
// tinker_exec_unit
//   Decode + 64-bit integer ALU + I/O port block for the tinker multicycle
//   CPU. Decodes the 32-bit instruction into register-file controls, computes
//   the ALU / branch-target / input result combinationally, and owns the
//   registered status (halt, error) and the I/O port strobes.
//   Ports:
//     clk    in  clock, rising edge
//     reset  in  asynchronous, active-high
//     bus    tinker_exec_unit_if.slave (see interface file for signal list)
//   Build option:
//     MUL_DIV_EN  when defined, opcodes 0x1C (mul) and 0x1D (signed div) are
//                 implemented; otherwise they decode as illegal and no
//                 multiplier/divider is built.
module tinker_exec_unit #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  tinker_exec_unit_if.slave bus
);

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_BR     = 5'h08;
  localparam logic [4:0] OP_BRR    = 5'h09;
  localparam logic [4:0] OP_BRRL   = 5'h0A;
  localparam logic [4:0] OP_BRNZ   = 5'h0B;
  localparam logic [4:0] OP_BRGT   = 5'h0E;
  localparam logic [4:0] OP_PRIV   = 5'h0F;
  localparam logic [4:0] OP_MOV    = 5'h11;
  localparam logic [4:0] OP_MOVL   = 5'h12;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1A;
  localparam logic [4:0] OP_SUBI   = 5'h1B;
  localparam logic [4:0] OP_MUL    = 5'h1C;
  localparam logic [4:0] OP_DIV    = 5'h1D;

  localparam logic [11:0] PRIV_HALT = 12'd0;
  localparam logic [11:0] PRIV_IN   = 12'd3;
  localparam logic [11:0] PRIV_OUT  = 12'd4;

  logic [4:0]      opcode_s;
  logic [11:0]     l_s;
  logic [XLEN-1:0] l_zext_s;
  logic [XLEN-1:0] l_sext_s;
  logic [XLEN-1:0] alu_result_s;
  logic            writes_rd_s;
  logic            br_taken_s;
  logic            illegal_s;
  logic            div_zero_s;
  logic            halt_op_s;
  logic            in_op_s;
  logic            out_op_s;
  logic            commit_s;

  logic            halt_r;
  logic            error_r;
  logic            in_signal_r;
  logic            out_signal_r;
  logic [XLEN-1:0] out_data_r;

  assign opcode_s = bus.instr[31:27];
  assign l_s      = bus.instr[11:0];
  assign l_zext_s = {{(XLEN-12){1'b0}}, l_s};
  assign l_sext_s = {{(XLEN-12){l_s[11]}}, l_s};

  assign bus.rd = bus.instr[26:22];
  assign bus.rs = bus.instr[21:17];
  assign bus.rt = bus.instr[16:12];
  assign bus.L  = l_s;

  // Once halted, nothing may write back or redirect the PC.
  assign bus.reg_write  = bus.exec_en & writes_rd_s & ~halt_r;
  assign bus.pc_src     = br_taken_s & ~halt_r;
  assign bus.alu_result = alu_result_s;

  assign bus.halt       = halt_r;
  assign bus.error      = error_r;
  assign bus.in_signal  = in_signal_r;
  assign bus.out_signal = out_signal_r;
  assign bus.out_data   = out_data_r;

  assign commit_s = bus.exec_en & ~halt_r;

  // Instruction decode and ALU / branch-target / input-port result.
  always_comb begin
    alu_result_s = {XLEN{1'b0}};
    writes_rd_s  = 1'b0;
    br_taken_s   = 1'b0;
    illegal_s    = 1'b0;
    div_zero_s   = 1'b0;
    halt_op_s    = 1'b0;
    in_op_s      = 1'b0;
    out_op_s     = 1'b0;
    case (opcode_s)
      OP_AND:    begin alu_result_s = bus.rs_data & bus.rt_data; writes_rd_s = 1'b1; end
      OP_OR:     begin alu_result_s = bus.rs_data | bus.rt_data; writes_rd_s = 1'b1; end
      OP_XOR:    begin alu_result_s = bus.rs_data ^ bus.rt_data; writes_rd_s = 1'b1; end
      OP_NOT:    begin alu_result_s = ~bus.rs_data;              writes_rd_s = 1'b1; end
      // Shift amounts use only the low 6 bits of the operand.
      OP_SHFTR:  begin alu_result_s = bus.rs_data >> bus.rt_data[5:0]; writes_rd_s = 1'b1; end
      OP_SHFTRI: begin alu_result_s = bus.rd_data >> l_s[5:0];         writes_rd_s = 1'b1; end
      OP_SHFTL:  begin alu_result_s = bus.rs_data << bus.rt_data[5:0]; writes_rd_s = 1'b1; end
      OP_SHFTLI: begin alu_result_s = bus.rd_data << l_s[5:0];         writes_rd_s = 1'b1; end
      OP_BR:     begin alu_result_s = bus.rd_data;            br_taken_s = 1'b1; end
      OP_BRR:    begin alu_result_s = bus.pc + bus.rd_data;   br_taken_s = 1'b1; end
      OP_BRRL:   begin alu_result_s = bus.pc + l_sext_s;      br_taken_s = 1'b1; end
      OP_BRNZ:   begin
        alu_result_s = bus.rd_data;
        br_taken_s   = (bus.rs_data != {XLEN{1'b0}});
      end
      OP_BRGT:   begin
        alu_result_s = bus.rd_data;
        br_taken_s   = ($signed(bus.rs_data) > $signed(bus.rt_data));
      end
      OP_PRIV:   begin
        case (l_s)
          PRIV_HALT: halt_op_s = 1'b1;
          PRIV_IN:   begin
            alu_result_s = bus.in_data;
            writes_rd_s  = 1'b1;
            in_op_s      = 1'b1;
          end
          PRIV_OUT:  out_op_s  = 1'b1;
          default:   illegal_s = 1'b1;
        endcase
      end
      OP_MOV:    begin alu_result_s = bus.rs_data;                      writes_rd_s = 1'b1; end
      // Only the low 12 bits of rd are replaced; the rest are preserved.
      OP_MOVL:   begin alu_result_s = {bus.rd_data[XLEN-1:12], l_s};    writes_rd_s = 1'b1; end
      OP_ADD:    begin alu_result_s = bus.rs_data + bus.rt_data;        writes_rd_s = 1'b1; end
      OP_ADDI:   begin alu_result_s = bus.rd_data + l_zext_s;           writes_rd_s = 1'b1; end
      OP_SUB:    begin alu_result_s = bus.rs_data - bus.rt_data;        writes_rd_s = 1'b1; end
      OP_SUBI:   begin alu_result_s = bus.rd_data - l_zext_s;           writes_rd_s = 1'b1; end
`ifdef MUL_DIV_EN
      OP_MUL:    begin alu_result_s = bus.rs_data * bus.rt_data;        writes_rd_s = 1'b1; end
      OP_DIV:    begin
        // Divide by zero yields 0, suppresses the write and flags an error.
        if (bus.rt_data == {XLEN{1'b0}}) begin
          div_zero_s = 1'b1;
        end else begin
          alu_result_s = $unsigned($signed(bus.rs_data) / $signed(bus.rt_data));
          writes_rd_s  = 1'b1;
        end
      end
`else
      OP_MUL:    illegal_s = 1'b1;
      OP_DIV:    illegal_s = 1'b1;
`endif
      default:   illegal_s = 1'b1;
    endcase
  end

  // Sticky halt/error, one-cycle I/O strobes and the output-port register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_r       <= 1'b0;
      error_r      <= 1'b0;
      in_signal_r  <= 1'b0;
      out_signal_r <= 1'b0;
      out_data_r   <= {XLEN{1'b0}};
    end else begin
      in_signal_r  <= commit_s & in_op_s;
      out_signal_r <= commit_s & out_op_s;
      if (commit_s && halt_op_s) begin
        halt_r <= 1'b1;
      end
      if (commit_s && (illegal_s || div_zero_s)) begin
        error_r <= 1'b1;
      end
      if (commit_s && out_op_s) begin
        out_data_r <= bus.rs_data;
      end
    end
  end

endmodule

// File: tb/tb_tinker_exec_unit.sv
// tb_tinker_exec_unit
//   Directed-vector bench for tinker_exec_unit. Expected values are
//   hand-computed constants; every comparison goes through check_val.
module tb_tinker_exec_unit;

  logic clk;
  logic reset;
  int   check_cnt;
  int   fail_cnt;

  tinker_exec_unit_if bus ();

  tinker_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt = check_cnt + 1;
    if (obs !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [11:0] l);
    return {op, rd, rs, rt, l};
  endfunction

  task automatic set_ops(input logic [63:0] rd_v, input logic [63:0] rs_v, input logic [63:0] rt_v);
    bus.rd_data = rd_v;
    bus.rs_data = rs_v;
    bus.rt_data = rt_v;
  endtask

  // Drive at negedge, check comb outputs, then commit on the next posedge.
  // Returns #1 after that edge with exec_en already dropped.
  task automatic exec_op(input string tag, input logic [31:0] ins,
                         input logic [63:0] exp_alu, input logic exp_wr, input logic exp_pc);
    @(negedge clk);
    bus.instr   = ins;
    bus.exec_en = 1'b1;
    #1;
    check_val({tag, "_alu"}, bus.alu_result, exp_alu);
    check_val({tag, "_wr"},  {63'd0, bus.reg_write}, {63'd0, exp_wr});
    check_val({tag, "_pc"},  {63'd0, bus.pc_src},    {63'd0, exp_pc});
    @(posedge clk);
    #1;
    bus.exec_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    check_cnt   = 0;
    fail_cnt    = 0;
    reset       = 1'b1;
    bus.exec_en = 1'b0;
    bus.instr   = 32'd0;
    bus.pc      = 64'h0000_0000_0000_1000;
    bus.in_data = 64'd0;
    set_ops(64'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_halt",  {63'd0, bus.halt},       64'd0);
    check_val("rst_error", {63'd0, bus.error},      64'd0);
    check_val("rst_in",    {63'd0, bus.in_signal},  64'd0);
    check_val("rst_out",   {63'd0, bus.out_signal}, 64'd0);
    check_val("rst_odata", bus.out_data,            64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Field extraction.
    bus.instr = mk(5'h05, 5'd9, 5'd17, 5'd30, 12'h004);
    #1;
    check_val("fld_rd", {59'd0, bus.rd}, 64'd9);
    check_val("fld_rs", {59'd0, bus.rs}, 64'd17);
    check_val("fld_rt", {59'd0, bus.rt}, 64'd30);
    check_val("fld_L",  {52'd0, bus.L},  64'd4);

    set_ops(64'd0, 64'd5, 64'd7);
    exec_op("add", mk(5'h18, 5'd1, 5'd2, 5'd3, 12'd0), 64'd12, 1'b1, 1'b0);
    set_ops(64'd0, 64'd0, 64'd1);
    exec_op("sub", mk(5'h1A, 5'd1, 5'd2, 5'd3, 12'd0), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    set_ops(64'h0000_0000_0000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    exec_op("brgt_nt", mk(5'h0E, 5'd1, 5'd2, 5'd3, 12'd0), 64'h2000, 1'b0, 1'b0);
    set_ops(64'h0000_0000_0000_2000, 64'd3, 64'd2);
    exec_op("brgt_t", mk(5'h0E, 5'd1, 5'd2, 5'd3, 12'd0), 64'h2000, 1'b0, 1'b1);
    set_ops(64'h0000_0000_0000_0100, 64'd0, 64'd0);
    exec_op("shftri", mk(5'h05, 5'd1, 5'd2, 5'd3, 12'h004), 64'h10, 1'b1, 1'b0);
    set_ops(64'd0, 64'h8000_0000_0000_0000, 64'h43);
    exec_op("shftr6", mk(5'h04, 5'd1, 5'd2, 5'd3, 12'd0), 64'h1000_0000_0000_0000, 1'b1, 1'b0);
    set_ops(64'h20, 64'd0, 64'd0);
    exec_op("brr", mk(5'h09, 5'd1, 5'd2, 5'd3, 12'd0), 64'h1020, 1'b0, 1'b1);
    exec_op("brrL", mk(5'h0A, 5'd1, 5'd2, 5'd3, 12'hFFC), 64'h0FFC, 1'b0, 1'b1);
    set_ops(64'hFFFF_0000_0000_0FFF, 64'd0, 64'd0);
    exec_op("movl", mk(5'h12, 5'd1, 5'd2, 5'd3, 12'h123), 64'hFFFF_0000_0000_0123, 1'b1, 1'b0);
    exec_op("addi", mk(5'h19, 5'd1, 5'd2, 5'd3, 12'h001), 64'hFFFF_0000_0000_1000, 1'b1, 1'b0);
    set_ops(64'h4000, 64'd0, 64'd0);
    exec_op("brnz_nt", mk(5'h0B, 5'd1, 5'd2, 5'd3, 12'd0), 64'h4000, 1'b0, 1'b0);
    set_ops(64'd0, 64'hF0F0, 64'h0FF0);
    exec_op("xor", mk(5'h02, 5'd1, 5'd2, 5'd3, 12'd0), 64'hFF00, 1'b1, 1'b0);

    // Output port.
    set_ops(64'd0, 64'hABCD, 64'd0);
    exec_op("out", mk(5'h0F, 5'd1, 5'd2, 5'd3, 12'd4), 64'd0, 1'b0, 1'b0);
    check_val("out_pulse", {63'd0, bus.out_signal}, 64'd1);
    check_val("out_data",  bus.out_data,            64'hABCD);
    @(posedge clk);
    #1;
    check_val("out_clr",   {63'd0, bus.out_signal}, 64'd0);

    // Input port.
    bus.in_data = 64'h55;
    exec_op("in", mk(5'h0F, 5'd1, 5'd2, 5'd3, 12'd3), 64'h55, 1'b1, 1'b0);
    check_val("in_pulse", {63'd0, bus.in_signal}, 64'd1);
    @(posedge clk);
    #1;
    check_val("in_clr",   {63'd0, bus.in_signal}, 64'd0);
    check_val("err_none", {63'd0, bus.error},     64'd0);

    // Divide by zero (illegal in default build): no write, error set.
    set_ops(64'd0, 64'd9, 64'd0);
    exec_op("div0", mk(5'h1D, 5'd1, 5'd2, 5'd3, 12'd0), 64'd0, 1'b0, 1'b0);
    check_val("div0_err", {63'd0, bus.error}, 64'd1);

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_err",   {63'd0, bus.error}, 64'd0);
    check_val("arst_odata", bus.out_data,       64'd0);
    @(negedge clk);
    reset = 1'b0;

    exec_op("op14", mk(5'h14, 5'd1, 5'd2, 5'd3, 12'd0), 64'd0, 1'b0, 1'b0);
    check_val("op14_err", {63'd0, bus.error}, 64'd1);
    pulse_reset();

    set_ops(64'd0, 64'd6, 64'd7);
`ifdef MUL_DIV_EN
    exec_op("mul", mk(5'h1C, 5'd1, 5'd2, 5'd3, 12'd0), 64'd42, 1'b1, 1'b0);
    check_val("mul_err", {63'd0, bus.error}, 64'd0);
    set_ops(64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    exec_op("div", mk(5'h1D, 5'd1, 5'd2, 5'd3, 12'd0), 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
`else
    exec_op("mul", mk(5'h1C, 5'd1, 5'd2, 5'd3, 12'd0), 64'd0, 1'b0, 1'b0);
    check_val("mul_err", {63'd0, bus.error}, 64'd1);
`endif
    pulse_reset();

    // Halt, then everything is ignored.
    exec_op("halt", mk(5'h0F, 5'd1, 5'd2, 5'd3, 12'd0), 64'd0, 1'b0, 1'b0);
    check_val("halt_set", {63'd0, bus.halt}, 64'd1);
    set_ops(64'h3000, 64'd5, 64'd7);
    exec_op("h_add", mk(5'h18, 5'd1, 5'd2, 5'd3, 12'd0), 64'd12, 1'b0, 1'b0);
    exec_op("h_br",  mk(5'h08, 5'd1, 5'd2, 5'd3, 12'd0), 64'h3000, 1'b0, 1'b0);
    exec_op("h_ill", mk(5'h1F, 5'd1, 5'd2, 5'd3, 12'd0), 64'd0, 1'b0, 1'b0);
    check_val("h_err",  {63'd0, bus.error}, 64'd0);
    exec_op("h_out", mk(5'h0F, 5'd1, 5'd2, 5'd3, 12'd4), 64'd0, 1'b0, 1'b0);
    check_val("h_outp", {63'd0, bus.out_signal}, 64'd0);
    check_val("h_stay", {63'd0, bus.halt},       64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
